seg7_scan_driver: RTL and testbench

Parametrised N-digit multiplexed 7-segment display driver. It is the sequential successor to the team's single-digit combinational 4-bit decoder. The block latches a packed hex word through a load/ack handshake and applies it only at frame boundaries, so digits never tear. It time-multiplexes one shared segment bus across N digit enables, with a blanking gap between digits to suppress ghosting. It also provides per-digit blanking and leading-zero suppression, and sits between the datapath/FSM and the board display pins.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_scan_driver_if.sv | 21 ++
 rtl/hex7_decode.sv | 9 +
 rtl/seg7_scan_driver.sv | 148 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: hex decode table, segment
// bit positions, scan phase encoding and the output polarity helper.
package seg7_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Active-high a..g patterns for hex digits 0..F
    localparam logic [6:0] HEX7_TABLE [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    typedef enum logic [1:0] {
        PH_BLANK = 2'd0,
        PH_SHOW  = 2'd1,
        PH_DARK  = 2'd2
    } phase_t;

    function automatic logic [6:0] apply_polarity(input logic [6:0] pattern,
                                                  input bit active_low);
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load/ack bus between the datapath and the 7-segment scan driver.
interface seg7_scan_driver_if #(
    parameter int N_DIGITS = 4
) ();
    logic                    load;
    logic [4*N_DIGITS-1:0]   data;
    logic [N_DIGITS-1:0]     blank_mask;
    logic                    lzs;
    logic                    load_ack;
    logic                    pending;

    modport master (
        output load, data, blank_mask, lzs,
        input  load_ack, pending
    );

    modport slave (
        input  load, data, blank_mask, lzs,
        output load_ack, pending
    );
endinterface

// File: rtl/hex7_decode.sv
// Combinational nibble to active-high a..g segment pattern.
module hex7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);
    assign pattern = HEX7_TABLE[nibble];
endmodule

// File: rtl/seg7_scan_driver.sv
// N-digit multiplexed 7-segment driver: frame-synchronous display updates,
// inter-digit blanking gap, per-digit masking and leading-zero suppression.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int SLOT_CYC       = 50000,
    parameter int BLANK_CYC      = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_driver_if.slave   bus,
    output logic [6:0]          seg,
    output logic [N_DIGITS-1:0] dig_en,
    output phase_t              phase
);
    localparam int CW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic [6:0] SEG_OFF = apply_polarity(7'h00, SEG_ACTIVE_LOW);
    localparam logic [N_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? '1 : '0;

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic                    frame_end;

    logic [4*N_DIGITS-1:0]   shadow_data, disp_data;
    logic [N_DIGITS-1:0]     shadow_mask, disp_mask;
    logic                    shadow_lzs, disp_lzs;
    logic                    pending_q, ack_q;

    logic [3:0]              nibble;
    logic [6:0]              pattern;
    logic [N_DIGITS-1:0]     supp;
    logic                    all_zero;
    logic                    dark;
    logic [N_DIGITS-1:0]     onehot;

    phase_t                  phase_d;
    logic [6:0]              seg_d;
    logic [N_DIGITS-1:0]     dig_d;

    assign frame_end = (cnt == CNT_LAST) && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Handshake: load is a one-cycle strobe with no backpressure; the word is
    // always accepted into the shadow (latest wins) and pending stays high until
    // the next frame_end copies it to the display, which pulses load_ack once
    // in the following cycle. A load on frame_end itself goes straight through.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_data <= '0;
            shadow_mask <= '0;
            shadow_lzs  <= 1'b0;
            disp_data   <= '0;
            disp_mask   <= '0;
            disp_lzs    <= 1'b0;
            pending_q   <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            if (bus.load) begin
                shadow_data <= bus.data;
                shadow_mask <= bus.blank_mask;
                shadow_lzs  <= bus.lzs;
            end
            if (frame_end && bus.load) begin
                disp_data <= bus.data;
                disp_mask <= bus.blank_mask;
                disp_lzs  <= bus.lzs;
                pending_q <= 1'b0;
                ack_q     <= 1'b1;
            end else if (frame_end && pending_q) begin
                disp_data <= shadow_data;
                disp_mask <= shadow_mask;
                disp_lzs  <= shadow_lzs;
                pending_q <= 1'b0;
                ack_q     <= 1'b1;
            end else if (bus.load) begin
                pending_q <= 1'b1;
            end
        end
    end

    assign bus.load_ack = ack_q;
    assign bus.pending  = pending_q;

    assign nibble = disp_data[{idx, 2'b00} +: 4];

    hex7_decode u_decode (
        .nibble  (nibble),
        .pattern (pattern)
    );

    // A digit above 0 is suppressed when it and every digit above it are zero
    always_comb begin
        all_zero = 1'b1;
        supp     = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (disp_data[4*i +: 4] == 4'h0);
            supp[i]  = disp_lzs && all_zero && (i != 0);
        end
    end

    assign dark   = disp_mask[idx] || supp[idx];
    assign onehot = N_DIGITS'(1) << idx;

    always_comb begin
        phase_d = PH_SHOW;
        seg_d   = SEG_OFF;
        dig_d   = DIG_OFF;
        if (int'(cnt) < BLANK_CYC) begin
            phase_d = PH_BLANK;
        end else if (dark) begin
            phase_d = PH_DARK;
        end else begin
            seg_d = apply_polarity(pattern, SEG_ACTIVE_LOW);
            dig_d = DIG_ACTIVE_LOW ? ~onehot : onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase  <= PH_BLANK;
            seg    <= SEG_OFF;
            dig_en <= DIG_OFF;
        end else begin
            phase  <= phase_d;
            seg    <= seg_d;
            dig_en <= dig_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a frame-arithmetic reference model
// predicts every cycle's outputs; a negedge monitor pops and compares.
module tb_seg7_scan_driver;
    import seg7_pkg::*;

    localparam int N     = 4;
    localparam int SLOT  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = N * SLOT;

    localparam logic [6:0] REF_SEG [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  mask;
        logic        lzs;
    } content_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.N_DIGITS(N)) bus ();
    logic [6:0]   seg;
    logic [N-1:0] dig_en;
    phase_t       phase;

    seg7_scan_driver #(
        .N_DIGITS       (N),
        .SLOT_CYC       (SLOT),
        .BLANK_CYC      (BLANK),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .seg    (seg),
        .dig_en (dig_en),
        .phase  (phase)
    );

    // scoreboard state: {ack, pending, dig_en[3:0], seg[6:0]}
    logic [12:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    // reference model state
    int       edge_n   = 0;
    content_t disp_m   = '0;
    content_t pend_m   = '0;
    bit       has_pend = 1'b0;
    int       pend_at  = 0;

    // Output for scan position p (cycles since reset) showing content c
    function automatic logic [10:0] ref_out(input int p, input content_t c);
        int pos;
        int slot;
        logic [15:0] upper;
        pos  = p % SLOT;
        slot = (p / SLOT) % N;
        if (pos < BLANK) return {4'hF, 7'h7F};
        upper = c.data >> (4 * slot);
        if (c.mask[slot] || (c.lzs && slot > 0 && upper == 16'h0000))
            return {4'hF, 7'h7F};
        return {~(4'b0001 << slot), ~REF_SEG[upper[3:0]]};
    endfunction

    // A load at edge e becomes visible at the first frame boundary edge >= e;
    // outputs produced at edge e still show the content held before that edge.
    always @(posedge clk) begin : model_p
        logic        ack_m;
        logic [10:0] o;
        if (rst) begin
            edge_n   = 0;
            disp_m   = '0;
            has_pend = 1'b0;
            exp_q.push_back({2'b00, 4'hF, 7'h7F});
        end else begin
            edge_n = edge_n + 1;
            o = ref_out(edge_n - 1, disp_m);
            if (bus.load) begin
                pend_m   = '{data: bus.data, mask: bus.blank_mask, lzs: bus.lzs};
                has_pend = 1'b1;
                pend_at  = ((edge_n + FRAME - 1) / FRAME) * FRAME;
            end
            ack_m = 1'b0;
            if (has_pend && edge_n == pend_at) begin
                disp_m   = pend_m;
                has_pend = 1'b0;
                ack_m    = 1'b1;
            end
            exp_q.push_back({ack_m, has_pend, o});
        end
    end

    function automatic void check(input string name, input logic [7:0] act,
                                  input logic [7:0] want);
        total = total + 1;
        if (act !== want) begin
            bad = bad + 1;
            $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, want);
        end
    endfunction

    always @(negedge clk) begin : monitor_p
        logic [12:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("seg",      {1'b0, seg},           {1'b0, e[6:0]});
            check("dig_en",   {4'b0, dig_en},        {4'b0, e[10:7]});
            check("pending",  {7'b0, bus.pending},   {7'b0, e[11]});
            check("load_ack", {7'b0, bus.load_ack},  {7'b0, e[12]});
        end
    end

    // driver tasks
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] m, input logic l);
        bus.load       = 1'b1;
        bus.data       = d;
        bus.blank_mask = m;
        bus.lzs        = l;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    // Wait until edge_n % FRAME == target, bounded to two frames
    task automatic wait_pos(input int target);
        int n;
        n = 0;
        while ((edge_n % FRAME) != target && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        total = total + 1;
        if ((edge_n % FRAME) != target) begin
            bad = bad + 1;
            $display("FAIL wait_pos: got=%0d want=%0d", edge_n % FRAME, target);
        end
    endtask

    initial begin : watchdog_p
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.load       = 1'b0;
        bus.data       = '0;
        bus.blank_mask = '0;
        bus.lzs        = 1'b0;
        rst            = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        cycles(5);
        do_load(16'h1234, 4'b0000, 1'b0);
        cycles(70);

        do_load(16'h0050, 4'b0000, 1'b1);
        cycles(70);
        do_load(16'h0000, 4'b0000, 1'b1);
        cycles(70);

        do_load(16'hAAAA, 4'b0000, 1'b0);
        cycles(3);
        do_load(16'hBBBB, 4'b0000, 1'b0);
        cycles(70);

        wait_pos(FRAME - 1);
        do_load(16'hC0DE, 4'b0000, 1'b0);
        cycles(40);

        do_load(16'h8888, 4'b0101, 1'b0);
        cycles(70);

        wait_pos(17);
        do_load(16'h9876, 4'b0000, 1'b0);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(40);

        repeat (25) begin
            do_load(16'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            cycles($urandom_range(0, 45));
        end
        cycles(70);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
